// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, bit-timer width, parity encodings and
// transmitter FSM states.
package uart_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 24;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // 2'b11 is treated as "no parity", same as PAR_NONE.
  function automatic logic parity_on(input logic [1:0] p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports: uart_clk/nrst (sync active-low reset), i_wr_en/i_wr_data (enqueue),
//        i_rd_en (pop), o_rd_data (registered head byte, valid the cycle after
//        a pop), o_full/o_empty (registered), o_overflow (sticky dropped write).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              uart_clk,
  input  logic              nrst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Acceptance uses the registered flags, so a full FIFO drops a write even
  // when a pop happens in the same cycle.
  assign w_wr_ok = i_wr_en && !r_full;
  assign w_rd_ok = i_rd_en && !r_empty;

  // Occupancy update.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array; no reset needed, contents are only read after being written.
  always_ff @(posedge uart_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + ADDR_W'(1);
      end
      if (w_rd_ok) begin
        r_rptr    <= r_rptr + ADDR_W'(1);
        r_rd_data <= r_mem[r_rptr];
      end
      if (i_wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_frame_encoder.sv
// Buffered UART transmitter: bytes are queued in a FIFO and sent as
// start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Ports: uart_clk/nrst (sync active-low reset), data_in/wr_en (enqueue),
//        parity/stop_sel/baudcontrol (frame config, latched at frame start),
//        tx (serial line), busy, empty, full, overflow, tx_done (end-of-frame pulse).
module uart_tx_frame_encoder
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4
) (
  input  logic              uart_clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic [1:0]        parity,
  input  logic              stop_sel,
  input  logic [BAUD_W-1:0] baudcontrol,
  output logic              tx,
  output logic              busy,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              tx_done
);

  tx_state_e         r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_timer, w_timer_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic [1:0]        r_par, w_par_nxt;
  logic              r_stop2, w_stop2_nxt;
  logic              r_stop_cnt, w_stop_cnt_nxt;
  logic              r_tx, w_tx_nxt;
  logic              r_tx_done, w_done_nxt;
  logic              r_busy;
  logic              w_pop;
  logic              w_empty;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_rd_data;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_fifo (
    .uart_clk  (uart_clk),
    .nrst      (nrst),
    .i_wr_en   (wr_en),
    .i_wr_data (data_in),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (full),
    .o_empty   (w_empty),
    .o_overflow(overflow)
  );

  assign w_bit_end = (r_timer == '0);

  // Next-state and output logic. tx is registered from the current state, so
  // the line trails the FSM by one cycle; busy and tx_done are aligned to it.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_baud_nxt     = r_baud;
    w_bit_idx_nxt  = r_bit_idx;
    w_shreg_nxt    = r_shreg;
    w_par_nxt      = r_par;
    w_stop2_nxt    = r_stop2;
    w_stop_cnt_nxt = r_stop_cnt;
    w_tx_nxt       = 1'b1;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_par_nxt   = parity;
          w_stop2_nxt = stop_sel;
          w_baud_nxt  = baudcontrol;
          w_timer_nxt = baudcontrol;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) begin
          // Popped byte is valid in the FIFO read register by now.
          w_shreg_nxt   = w_rd_data;
          w_bit_idx_nxt = '0;
          w_timer_nxt   = r_baud;
          w_state_nxt   = S_DATA;
        end else begin
          w_timer_nxt = r_timer - BAUD_W'(1);
        end
      end
      S_DATA: begin
        w_tx_nxt = r_shreg[r_bit_idx];
        if (w_bit_end) begin
          w_timer_nxt = r_baud;
          if (r_bit_idx == 3'd7) begin
            w_stop_cnt_nxt = 1'b0;
            w_state_nxt    = parity_on(r_par) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'(1);
          end
        end else begin
          w_timer_nxt = r_timer - BAUD_W'(1);
        end
      end
      S_PARITY: begin
        w_tx_nxt = (r_par == PAR_EVEN) ? ^r_shreg : ~^r_shreg;
        if (w_bit_end) begin
          w_timer_nxt    = r_baud;
          w_stop_cnt_nxt = 1'b0;
          w_state_nxt    = S_STOP;
        end else begin
          w_timer_nxt = r_timer - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_cnt) begin
            w_stop_cnt_nxt = 1'b1;
            w_timer_nxt    = r_baud;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - BAUD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge uart_clk) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shreg    <= '0;
      r_par      <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shreg    <= w_shreg_nxt;
      r_par      <= w_par_nxt;
      r_stop2    <= w_stop2_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_tx_done  <= w_done_nxt;
      r_busy     <= (r_state != S_IDLE);
    end
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign empty   = w_empty;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_tx_frame_encoder.sv
// Self-checking bench for uart_tx_frame_encoder: directed frames plus
// randomized traffic, compared every cycle against a frame-level model.
module tb_uart_tx_frame_encoder;

  logic        uart_clk = 1'b0;
  logic        nrst;
  logic [7:0]  data_in;
  logic        wr_en;
  logic [1:0]  parity;
  logic        stop_sel;
  logic [23:0] baudcontrol;
  logic        tx, busy, empty, full, overflow, tx_done;

  uart_tx_frame_encoder dut (
    .uart_clk   (uart_clk),
    .nrst       (nrst),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .parity     (parity),
    .stop_sel   (stop_sel),
    .baudcontrol(baudcontrol),
    .tx         (tx),
    .busy       (busy),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .tx_done    (tx_done)
  );

  always #5 uart_clk = ~uart_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Model: queued bytes, sticky overflow, and the frame currently on the line
  // (start cycle, bit length, bit list).
  logic [7:0] m_q[$];
  logic       m_ovf  = 1'b0;
  logic       m_have = 1'b0;
  int         m_s    = 0;
  int         m_len  = 0;
  int         m_bl   = 1;
  logic       m_bits[12];
  logic       e_tx, e_busy, e_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs held at that edge.
  // A frame popped at edge t is on the line from t+1; the transmitter is free
  // again once its last stop cycle has been shown.
  task automatic model_edge();
    int         nb;
    int         cnt;
    logic [7:0] b;
    cyc++;
    if (!nrst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_have = 1'b0;
    end else begin
      cnt = m_q.size();
      if ((!m_have || cyc >= m_s + m_len) && cnt > 0) begin
        b = m_q.pop_front();
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[i+1] = b[i];
        nb = 9;
        if (parity == 2'b01) begin m_bits[nb] = ^b;  nb++; end
        else if (parity == 2'b10) begin m_bits[nb] = ~^b; nb++; end
        m_bits[nb] = 1'b1; nb++;
        if (stop_sel) begin m_bits[nb] = 1'b1; nb++; end
        m_bl   = int'(baudcontrol) + 1;
        m_len  = m_bl * nb;
        m_s    = cyc + 1;
        m_have = 1'b1;
      end
      if (wr_en) begin
        if (cnt < 16) m_q.push_back(data_in);
        else m_ovf = 1'b1;
      end
    end
    if (m_have && cyc >= m_s && cyc < m_s + m_len) begin
      e_tx   = m_bits[(cyc - m_s) / m_bl];
      e_busy = 1'b1;
    end else begin
      e_tx   = 1'b1;
      e_busy = 1'b0;
    end
    e_done = m_have && (cyc == m_s + m_len - 1);
  endtask

  task automatic step();
    @(posedge uart_clk);
    model_edge();
    #1;
    check("tx",       32'(tx),       32'(e_tx));
    check("busy",     32'(busy),     32'(e_busy));
    check("tx_done",  32'(tx_done),  32'(e_done));
    check("empty",    32'(empty),    32'(m_q.size() == 0));
    check("full",     32'(full),     32'(m_q.size() == 16));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    int n_busy;
    int n_done;
    int rate[4];
    rate = '{5, 15, 40, 90};
    nrst = 1'b0; wr_en = 1'b0; data_in = '0;
    parity = 2'b00; stop_sel = 1'b0; baudcontrol = 24'd3;
    idle(3);
    nrst = 1'b1;
    idle(2);

    // 0x55, no parity, 1 stop, 4-cycle bits: 40-cycle frame, one tx_done.
    wr(8'h55);
    n_busy = 0; n_done = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      n_busy += int'(busy);
      n_done += int'(tx_done);
    end
    check("t1_frame_len", 32'(n_busy), 32'd40);
    check("t1_done_cnt",  32'(n_done), 32'd1);

    // 0x07 with even then odd parity, 2-cycle bits.
    baudcontrol = 24'd1; parity = 2'b01;
    wr(8'h07); idle(30);
    parity = 2'b10;
    wr(8'h07); idle(30);

    // 0xA3, two stop bits, 3-cycle bits.
    parity = 2'b00; stop_sel = 1'b1; baudcontrol = 24'd2;
    wr(8'hA3); idle(40);

    // Burst of 18 writes: one byte leaves for the line, the FIFO fills, the last is dropped.
    stop_sel = 1'b0; baudcontrol = 24'd3;
    for (int i = 0; i < 18; i++) wr(8'(i));
    check("t4_full",     32'(full),     32'd1);
    check("t4_overflow", 32'(overflow), 32'd1);
    idle(700);
    check("t4_drained",  32'(empty),    32'd1);

    // Reset during data bit 3 of 0xF0.
    wr(8'hF0);
    idle(18);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    idle(10);

    // Baud change mid-frame only affects the next queued frame.
    baudcontrol = 24'd3;
    wr(8'h3C); wr(8'hC3);
    idle(10);
    baudcontrol = 24'd7;
    idle(140);

    // Randomized traffic with config churn and occasional resets.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 1500; c++) begin
        wr_en   = ($urandom_range(99) < 32'(rate[r]));
        data_in = 8'($urandom);
        if ($urandom_range(19) == 0) begin
          parity      = 2'($urandom);
          stop_sel    = 1'($urandom);
          baudcontrol = 24'($urandom_range(3));
        end
        nrst = !($urandom_range(799) == 0);
        step();
      end
      wr_en = 1'b0;
      nrst  = 1'b1;
      idle(800);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
